psp_unpacker: RTL and testbench

Parallel-to-serial unpacker for the approximate-adder datapath; the transmit-side counterpart of the SSP serial-to-parallel packer. Accepts one wide word of 2**LANE_BITS lanes and emits it as DOUT_WIDTH-bit words, lane 0 (bits [DOUT_WIDTH-1:0]) first. It feeds narrow-operand adders from wide result buses. Valid/ready handshakes on both sides, plus a one-entry pending buffer, sustain 1 output word/cycle across back-to-back inputs.

---
 rtl/approx_adder_pkg.sv | 17 +
 rtl/psp_hold_reg.sv | 29 ++
 rtl/psp_unpacker.sv | 111 +++++++++++
 tb/tb_psp_unpacker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared types and constants for the approximate-adder serial/parallel converters (SSP packer, PSP unpacker).
package approx_adder_pkg;

  localparam int DOUT_WIDTH_DEFAULT = 8;
  localparam int LANE_BITS_DEFAULT  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } psp_state_t;

  function automatic int lane_count(input int lane_bits);
    return 1 << lane_bits;
  endfunction

endpackage

// File: rtl/psp_hold_reg.sv
// One-entry valid+data holding register; holds the word waiting behind the active one.
import approx_adder_pkg::*;

module psp_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // load wins over clear; the top never asserts both in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/psp_unpacker.sv
// Wide-to-narrow unpacker: emits each wide word lane 0 first, with a pending slot for gapless streaming.
// Optional dout_last output is enabled by defining PSP_UNPACKER_LAST_EN.
import approx_adder_pkg::*;

module psp_unpacker #(
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEFAULT,
  parameter int LANE_BITS  = LANE_BITS_DEFAULT,
  parameter int DIN_WIDTH  = (2**LANE_BITS) * DOUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DIN_WIDTH-1:0]  din,
  output logic                  din_ready,
  output logic                  dout_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  dout_ready
`ifdef PSP_UNPACKER_LAST_EN
  ,
  output logic                  dout_last
`endif
);

  localparam int   LANES  = lane_count(LANE_BITS);
  localparam int   LB     = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam logic [LB-1:0] LAST = LB'(LANES - 1);
  localparam logic SINGLE = (LANE_BITS == 0);

  psp_state_t state;
  logic [LB-1:0]         lane;
  logic [LB-1:0]         lane_inc;
  logic [DIN_WIDTH-1:0]  active;
  logic [DIN_WIDTH-1:0]  pend_data;
  logic                  pend_valid;
  logic [DOUT_WIDTH-1:0] next_lane_data;

  logic in_xfer, out_xfer, is_final, final_xfer;
  logic load_din, load_pend, go_empty, advance, pend_load;

  assign din_ready  = (state != FULL);
  assign in_xfer    = din_valid & din_ready;
  assign out_xfer   = dout_valid & dout_ready;
  assign is_final   = (lane == LAST);
  assign final_xfer = out_xfer & is_final;
  assign lane_inc   = lane + 1'b1;

  assign load_din  = in_xfer & ((state == EMPTY) | ((state == BUSY) & final_xfer));
  assign load_pend = (state == FULL) & pend_valid & final_xfer;
  assign go_empty  = (state == BUSY) & final_xfer & ~in_xfer;
  assign advance   = out_xfer & ~is_final;
  assign pend_load = (state == BUSY) & in_xfer & ~final_xfer;

  // Lane that becomes visible after a non-final transfer
  always_comb begin
    next_lane_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_inc == LB'(k)) next_lane_data = active[k*DOUT_WIDTH +: DOUT_WIDTH];
    end
  end

  psp_hold_reg #(.WIDTH(DIN_WIDTH)) u_pending (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load),
    .clear (load_pend),
    .d     (din),
    .valid (pend_valid),
    .q     (pend_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      lane       <= '0;
      active     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load_din) begin
      active     <= din;
      lane       <= '0;
      dout       <= din[DOUT_WIDTH-1:0];
      dout_valid <= 1'b1;
      state      <= BUSY;
    end else if (load_pend) begin
      active     <= pend_data;
      lane       <= '0;
      dout       <= pend_data[DOUT_WIDTH-1:0];
      state      <= BUSY;
    end else if (go_empty) begin
      dout_valid <= 1'b0;
      state      <= EMPTY;
    end else begin
      if (advance) begin
        lane <= lane_inc;
        dout <= next_lane_data;
      end
      if (pend_load) state <= FULL;
    end
  end

`ifdef PSP_UNPACKER_LAST_EN
  // Tracks the same events as dout so it stays aligned under backpressure
  always_ff @(posedge clk) begin
    if (!rst)                        dout_last <= 1'b0;
    else if (load_din || load_pend)  dout_last <= SINGLE;
    else if (go_empty)               dout_last <= 1'b0;
    else if (advance)                dout_last <= (lane_inc == LAST);
  end
`endif

endmodule

// File: tb/tb_psp_unpacker.sv
// Directed self-checking bench for psp_unpacker (default 8-bit lanes, 4 lanes per word).
module tb_psp_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        din_ready;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        dout_ready = 1'b0;
`ifdef PSP_UNPACKER_LAST_EN
  logic        dout_last;
`endif

  int total = 0;
  int bad   = 0;

  psp_unpacker dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready)
`ifdef PSP_UNPACKER_LAST_EN
    ,
    .dout_last  (dout_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    din_valid  = v;
    din        = d;
    dout_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic checkLane(input string tag, input logic [7:0] exp_data);
    checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(dout), 32'(exp_data));
  endtask

  logic [7:0] stream [8];
  int p;

  initial begin
    // Reset state
    applyReset();
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_ready", 32'(din_ready), 32'd1);

    // Single word
    $display("[TB] single word");
    applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1);
    tick();
    checkLane("t1_l0", 8'hAA);
`ifdef PSP_UNPACKER_LAST_EN
    checkOutput("t1_last0", 32'(dout_last), 32'd0);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); checkLane("t1_l1", 8'hBB);
    tick(); checkLane("t1_l2", 8'hCC);
    tick(); checkLane("t1_l3", 8'hDD);
`ifdef PSP_UNPACKER_LAST_EN
    checkOutput("t1_last3", 32'(dout_last), 32'd1);
`endif
    tick();
    checkOutput("t1_drop", 32'(dout_valid), 32'd0);
    checkOutput("t1_ready", 32'(din_ready), 32'd1);
`ifdef PSP_UNPACKER_LAST_EN
    checkOutput("t1_last_off", 32'(dout_last), 32'd0);
`endif

    // Back-to-back words, no bubble
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    tick();
    checkLane("t2_w0", 8'h11);
    checkOutput("t2_ready_busy", 32'(din_ready), 32'd1);
    applyStimulus(1'b1, 32'h88776655, 1'b1);
    tick();
    checkLane("t2_w1", 8'h22);
    checkOutput("t2_ready_full", 32'(din_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 2; k < 8; k++) begin
      tick();
      checkLane("t2_stream", 8'(8'h11 * (k + 1)));
      if (k == 4) checkOutput("t2_ready_after", 32'(din_ready), 32'd1);
    end
    tick();
    checkOutput("t2_drop", 32'(dout_valid), 32'd0);

    // Backpressure while BB is shown, second word parks in pending
    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1);
    tick(); checkLane("t3_aa", 8'hAA);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); checkLane("t3_bb", 8'hBB);
    applyStimulus(1'b1, 32'h04030201, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkLane("t3_hold", 8'hBB);
      checkOutput("t3_ready_full", 32'(din_ready), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); checkLane("t3_cc", 8'hCC);
    tick(); checkLane("t3_dd", 8'hDD);
    checkOutput("t3_ready_dd", 32'(din_ready), 32'd0);
    tick(); checkLane("t3_p0", 8'h01);
    checkOutput("t3_ready_busy", 32'(din_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick(); checkLane("t3_tail", 8'(i));
    end
    tick();
    checkOutput("t3_drop", 32'(dout_valid), 32'd0);

    // FULL drain with toggling dout_ready
    $display("[TB] full drain");
    stream = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    applyStimulus(1'b1, 32'hA3A2A1A0, 1'b0);
    tick(); checkLane("t4_a0", 8'hA0);
    applyStimulus(1'b1, 32'hB3B2B1B0, 1'b0);
    tick(); checkLane("t4_a0_hold", 8'hA0);
    checkOutput("t4_full", 32'(din_ready), 32'd0);
    p = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'h0, (i % 2) == 0);
      tick();
      if (dout_ready) p++;
      if (p < 8) begin
        checkLane("t4_drain", stream[p]);
        checkOutput("t4_ready", 32'(din_ready), (p < 4) ? 32'd0 : 32'd1);
      end else begin
        checkOutput("t4_drop", 32'(dout_valid), 32'd0);
      end
    end

    // Reset in the middle of a word with pending data
    $display("[TB] mid-word reset");
    applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1);
    tick(); checkLane("t5_aa", 8'hAA);
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    tick(); checkLane("t5_bb", 8'hBB);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); checkLane("t5_cc", 8'hCC);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("t5_valid", 32'(dout_valid), 32'd0);
    checkOutput("t5_dout", 32'(dout), 32'd0);
    checkOutput("t5_ready", 32'(din_ready), 32'd1);
    applyStimulus(1'b1, 32'h0A0B0C0D, 1'b1);
    tick(); checkLane("t5_0d", 8'h0D);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick(); checkLane("t5_0c", 8'h0C);
    tick(); checkLane("t5_0b", 8'h0B);
    tick(); checkLane("t5_0a", 8'h0A);
    tick();
    checkOutput("t5_drop", 32'(dout_valid), 32'd0);

    // Idle after reset
    $display("[TB] idle");
    applyReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'hFFFFFFFF, 1'b1);
      tick();
      checkOutput("t6_valid", 32'(dout_valid), 32'd0);
      checkOutput("t6_ready", 32'(din_ready), 32'd1);
      checkOutput("t6_dout", 32'(dout), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
